exc_ctrl: RTL and testbench

Exception/interrupt controller sitting directly upstream of the CP0 block in the multi-cycle MIPS core. It collects trap requests from the decoder (syscall, break, teq) and an external interrupt line, gates them with the CP0 Status register, prioritises them, and drives CP0's `exception`, `eret`, `cause` and `pc` inputs with a clean one-cycle pulse. It also stalls the fetch/decode path while CP0 commits EPC/Status/Cause.

---
 rtl/exc_pkg.sv | 23 ++
 rtl/irq_sync.sv | 27 ++
 rtl/exc_ctrl.sv | 145 ++++++++++++++
 tb/tb_exc_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared constants and state type for the exception/interrupt controller.
package exc_pkg;

    // CP0 ExcCode values
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    // CP0 Status bit positions
    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_SYS_EN = 1;
    localparam int unsigned ST_BRK_EN = 2;
    localparam int unsigned ST_TEQ_EN = 3;
    localparam int unsigned ST_IM     = 8;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        SETTLE
    } exc_state_t;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for the asynchronous irq line plus a rising-edge
// detector that emits a one-cycle irq_rise on the synchronised level.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], irq};
            level_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_rise = sync_q[SYNC_STAGES-1] & ~level_prev_q;

endmodule

// File: rtl/exc_ctrl.sv
// Trap/interrupt arbiter feeding CP0 with one-cycle exception/eret pulses.
// Optional interrupt path is built only when EXC_CTRL_IRQ_EN is defined.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        syscall,
    input  logic        brk,
    input  logic        teq,
    input  logic        eret_req,
    input  logic [31:0] pc,
    input  logic        irq,
    input  logic [31:0] status,
    output logic        exception,
    output logic        eret,
    output logic [4:0]  cause,
    output logic [31:0] exc_pc,
    output logic        stall,
    output logic        irq_pending
);

    exc_state_t  state_q, state_d;
    logic        is_eret_q, is_eret_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        accept;
    logic        take_int;
    logic        int_ready;
    logic        sync_req;

`ifdef EXC_CTRL_IRQ_EN
    logic irq_rise;
    logic pending_q;

    irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .irq_rise(irq_rise)
    );

    // A new edge arriving in the same cycle the interrupt is taken wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~take_int) | irq_rise;
        end
    end

    assign int_ready   = pending_q & status[ST_IE] & status[ST_IM];
    assign irq_pending = pending_q;
`else
    logic unused_irq;
    assign unused_irq  = ^{irq, status[ST_IM], take_int, SYNC_STAGES[0]};
    assign int_ready   = 1'b0;
    assign irq_pending = 1'b0;
`endif

    logic unused_status;
    assign unused_status = ^{status[31:9], status[7:4]};

    assign sync_req = eret_req | teq | brk | syscall;

    always_comb begin
        state_d   = state_q;
        is_eret_d = is_eret_q;
        cause_d   = cause_q;
        exc_pc_d  = exc_pc_q;
        accept    = 1'b0;
        take_int  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    // Only the highest-priority request is considered; if it is
                    // masked it is dropped rather than falling through.
                    if (eret_req) begin
                        accept    = 1'b1;
                        is_eret_d = 1'b1;
                        cause_d   = 5'd0;
                    end else if (teq) begin
                        if (status[ST_IE] && status[ST_TEQ_EN]) begin
                            accept    = 1'b1;
                            is_eret_d = 1'b0;
                            cause_d   = EXC_TEQ;
                        end
                    end else if (brk) begin
                        if (status[ST_IE] && status[ST_BRK_EN]) begin
                            accept    = 1'b1;
                            is_eret_d = 1'b0;
                            cause_d   = EXC_BREAK;
                        end
                    end else if (syscall) begin
                        if (status[ST_IE] && status[ST_SYS_EN]) begin
                            accept    = 1'b1;
                            is_eret_d = 1'b0;
                            cause_d   = EXC_SYSCALL;
                        end
                    end else if (!sync_req && int_ready) begin
                        accept    = 1'b1;
                        take_int  = 1'b1;
                        is_eret_d = 1'b0;
                        cause_d   = EXC_INT;
                    end

                    if (accept) begin
                        exc_pc_d = pc;
                        state_d  = FIRE;
                    end
                end
            end
            FIRE:    state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            is_eret_q <= 1'b0;
            cause_q   <= 5'd0;
            exc_pc_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            is_eret_q <= is_eret_d;
            cause_q   <= cause_d;
            exc_pc_q  <= exc_pc_d;
        end
    end

    assign exception = (state_q == FIRE) && !is_eret_q;
    assign eret      = (state_q == FIRE) && is_eret_q;
    assign stall     = (state_q != IDLE);
    assign cause     = cause_q;
    assign exc_pc    = exc_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes expected CP0 pulses, a
// monitor pops and compares on every exception/eret cycle.
module tb_exc_ctrl;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        syscall = 1'b0;
    logic        brk = 1'b0;
    logic        teq = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        irq = 1'b0;
    logic [31:0] status = 32'd0;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic        stall;
    logic        irq_pending;

    typedef struct packed {
        logic        exc;
        logic        er;
        logic [4:0]  cause;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cnt;
    logic seen;

    exc_ctrl #(
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .syscall    (syscall),
        .brk        (brk),
        .teq        (teq),
        .eret_req   (eret_req),
        .pc         (pc),
        .irq        (irq),
        .status     (status),
        .exception  (exception),
        .eret       (eret),
        .cause      (cause),
        .exc_pc     (exc_pc),
        .stall      (stall),
        .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic e, input logic r, input logic [4:0] c, input logic [31:0] p);
        exp_t x;
        x.exc   = e;
        x.er    = r;
        x.cause = c;
        x.pc    = p;
        q.push_back(x);
    endtask

    // One valid cycle of request fields, then drop them.
    task automatic issue(input logic sc, input logic bk, input logic tq, input logic er,
                         input logic [31:0] p, input logic [31:0] st);
        instr_valid = 1'b1;
        syscall     = sc;
        brk         = bk;
        teq         = tq;
        eret_req    = er;
        pc          = p;
        status      = st;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        syscall     = 1'b0;
        brk         = 1'b0;
        teq         = 1'b0;
        eret_req    = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_exception"}, exception, 1'b0);
        check({tag, "_eret"}, eret, 1'b0);
        check({tag, "_cause"}, cause, 5'd0);
        check({tag, "_exc_pc"}, exc_pc, 32'd0);
        check({tag, "_stall"}, stall, 1'b0);
        check({tag, "_irq_pending"}, irq_pending, 1'b0);
    endtask

    // Monitor
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (!rst && (exception || eret)) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse exception=%b eret=%b cause=%0d required=none",
                             exception, eret, cause);
                end else begin
                    e = q.pop_front();
                    check("pulse_exception", exception, e.exc);
                    check("pulse_eret", eret, e.er);
                    check("pulse_cause", cause, e.cause);
                    check("pulse_exc_pc", exc_pc, e.pc);
                    check("pulse_stall", stall, 1'b1);
                end
            end
        end
    end

    initial begin
        wait_cycles(2);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Syscall taken, stall exactly two cycles
        push(1'b1, 1'b0, 5'd8, 32'h10);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0000_000F);
        cnt = 0;
        repeat (4) begin
            cnt += int'(stall);
            @(posedge clk);
            #1;
        end
        check("syscall_stall_cycles", cnt, 2);
        check("syscall_cause_held", cause, 5'd8);
        check("syscall_pc_held", exc_pc, 32'h10);

        // Masked break dropped silently
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0000_0001);
        seen = 1'b0;
        repeat (3) begin
            seen |= stall | exception;
            @(posedge clk);
            #1;
        end
        check("masked_brk_no_activity", seen, 1'b0);

        // Enabled break
        push(1'b1, 1'b0, 5'd9, 32'h20);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0000_0005);
        wait_cycles(2);

        // Eret
        push(1'b0, 1'b1, 5'd0, 32'h40);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0000_0000);
        wait_cycles(2);

        // Request held through FIRE/SETTLE is taken only once
        push(1'b1, 1'b0, 5'd8, 32'h60);
        instr_valid = 1'b1;
        syscall     = 1'b1;
        pc          = 32'h60;
        status      = 32'h0000_000F;
        repeat (3) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        syscall     = 1'b0;
        check("busy_back_to_idle", stall, 1'b0);

        // Reset during FIRE
        push(1'b1, 1'b0, 5'd13, 32'h80);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0000_000F);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("rst_fire");

`ifdef EXC_CTRL_IRQ_EN
        // Interrupt latency: SYNC+1 clocks
        irq = 1'b1;
        wait_cycles(SYNC);
        check("irq_latency_early", irq_pending, 1'b0);
        wait_cycles(1);
        check("irq_latency_set", irq_pending, 1'b1);
        irq = 1'b0;

        // Masked by status[8]: flag holds, nothing fires
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h88, 32'h0000_0001);
        wait_cycles(2);
        check("irq_masked_holds", irq_pending, 1'b1);
        check("irq_masked_no_stall", stall, 1'b0);

        // Synchronous trap beats pending interrupt
        push(1'b1, 1'b0, 5'd13, 32'h90);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h90, 32'h0000_010F);
        check("prio_irq_still_pending", irq_pending, 1'b1);
        wait_cycles(2);

        // Next idle valid cycle takes the interrupt
        push(1'b1, 1'b0, 5'd0, 32'hA0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'hA0, 32'h0000_010F);
        check("irq_taken_clears", irq_pending, 1'b0);
        wait_cycles(2);

        // Gating then enabling via status 0x101
        irq = 1'b1;
        wait_cycles(SYNC + 2);
        irq = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'hB0, 32'h0000_0001);
        wait_cycles(2);
        check("irq_gate_pending", irq_pending, 1'b1);
        push(1'b1, 1'b0, 5'd0, 32'hB4);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'hB4, 32'h0000_0101);
        check("irq_enable_clears", irq_pending, 1'b0);
        wait_cycles(2);
`else
        // Interrupt path absent: irq must never produce anything
        irq = 1'b1;
        wait_cycles(SYNC + 3);
        irq = 1'b0;
        check("noirq_pending", irq_pending, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'hC0, 32'h0000_0101);
        seen = 1'b0;
        repeat (3) begin
            seen |= stall | exception;
            @(posedge clk);
            #1;
        end
        check("noirq_no_exception", seen, 1'b0);
`endif

        wait_cycles(3);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
